// File: rtl/ldpc_frame_io_ctrl.sv
// ---------------------------------------------------------------------------
// ldpc_frame_io_ctrl
//
// Frame controller placed around the LDPC parallel encoder core.
//   Input side : takes bit BIT_SEL of the packet bus, counts K_BITS message
//                bits per frame and drives the core's serial bit interface.
//   Output side: tags each OUT_W-bit encoder word with start/end of frame and
//                queues it in a FIFO_DEPTH-entry FIFO with valid/ready
//                backpressure.
//   Flags      : next_frame (ready for a new frame), sticky ovf_err (word
//                dropped on a full FIFO), sticky proto_err (encoder word
//                arrived while idle).
//
// Optional feature macro: LDPC_FRAME_CNT_EN
//   defined   -> frame_cnt counts pushed end-of-frame words (16-bit wrap)
//   undefined -> frame_cnt is tied to 0 and no counter is built
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   clk_enable      global enable, every register holds while low
//   pkt_in          packet bus, pkt_in[BIT_SEL] is the message bit
//   pkt_valid       pkt_in carries a bit this cycle
//   next_frame      high while idle and ready for the first bit of a frame
//   core_bit        message bit to the encoder core
//   core_bit_vld    core_bit valid
//   core_start      one-cycle pulse alongside the first bit of each frame
//   enc_valid       encoder core word valid
//   enc_data        encoder core word
//   out_valid       FIFO head valid
//   out_ready       downstream accepts the head word
//   out_data        FIFO head word
//   out_sof         head word is word 0 of its frame
//   out_eof         head word is word N_WORDS-1 of its frame
//   ovf_err         sticky overflow flag
//   proto_err       sticky protocol flag
//   frame_cnt       completed frames pushed into the FIFO
// ---------------------------------------------------------------------------
module ldpc_frame_io_ctrl #(
   parameter int PKT_W      = 6,
   parameter int BIT_SEL    = 5,
   parameter int K_BITS     = 1024,
   parameter int N_WORDS    = 64,
   parameter int OUT_W      = 19,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_enable,
   input  logic [PKT_W-1:0] pkt_in,
   input  logic             pkt_valid,
   output logic             next_frame,
   output logic             core_bit,
   output logic             core_bit_vld,
   output logic             core_start,
   input  logic             enc_valid,
   input  logic [OUT_W-1:0] enc_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sof,
   output logic             out_eof,
   output logic             ovf_err,
   output logic             proto_err,
   output logic [15:0]      frame_cnt
);

   localparam int BW = $clog2(K_BITS);
   localparam int WW = $clog2(N_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [BW-1:0] BIT_LAST  = BW'(K_BITS - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);
   localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN
   } state_t;

   state_t state, state_next;

   logic [BW-1:0] bit_cnt;
   logic [WW-1:0] word_cnt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_count;
   logic [OUT_W+1:0] fifo_mem [FIFO_DEPTH];
   logic [OUT_W+1:0] head;

   logic accept, word_take, word_last, bit_last;
   logic fifo_full, do_push, do_pop, push_drop;

   // Only pkt_in[BIT_SEL] carries information; the other lanes are ignored.
   logic unused_pkt_bits;
   assign unused_pkt_bits = ^pkt_in;

   // Handshake decode and next-state logic. A word arriving on a full FIFO
   // is still accepted when a pop frees a slot in the same cycle.
   always_comb begin
      accept     = clk_enable & pkt_valid & ((state == IDLE) | (state == LOAD));
      word_take  = clk_enable & enc_valid & (state != IDLE);
      word_last  = (word_cnt == WORD_LAST);
      bit_last   = (bit_cnt == BIT_LAST);
      do_pop     = clk_enable & out_valid & out_ready;
      fifo_full  = (fifo_count == FIFO_FULL);
      do_push    = word_take & (~fifo_full | do_pop);
      push_drop  = word_take & fifo_full & ~do_pop;
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = LOAD;
         LOAD:    if (accept && bit_last) state_next = DRAIN;
         DRAIN:   if (word_take && word_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else if (clk_enable)
         state <= state_next;
   end

   // Input path toward the core. bit_cnt is 0 whenever the FSM is idle, so
   // the first accepted bit naturally loads 1; the last bit of the frame
   // returns it to 0. next_frame is registered so it reads 0 under reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_bit     <= 1'b0;
         core_bit_vld <= 1'b0;
         core_start   <= 1'b0;
         next_frame   <= 1'b0;
         bit_cnt      <= '0;
      end else if (clk_enable) begin
         core_bit     <= pkt_in[BIT_SEL];
         core_bit_vld <= accept;
         core_start   <= accept & (state == IDLE);
         next_frame   <= (state_next == IDLE);
         if (accept)
            bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      end
   end

   // Word tagging, FIFO pointers and sticky flags. word_cnt advances even on
   // a dropped word so the sof/eof tags of later words stay frame-aligned.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         ovf_err    <= 1'b0;
         proto_err  <= 1'b0;
      end else if (clk_enable) begin
         if (word_take)
            word_cnt <= word_last ? '0 : word_cnt + WW'(1);
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push_drop)
            ovf_err <= 1'b1;
         if (enc_valid && (state == IDLE))
            proto_err <= 1'b1;
      end
   end

   // FIFO storage, entry = {sof, eof, data}. On a full push+pop the write
   // slot equals the head slot; the head is read before the edge overwrites it.
   always_ff @(posedge clk) begin
      if (rst_n && do_push)
         fifo_mem[wr_ptr] <= {(word_cnt == '0), word_last, enc_data};
   end

   // Head outputs are forced to 0 while empty so reset leaves them at 0.
   assign head      = fifo_mem[rd_ptr];
   assign out_valid = (fifo_count != '0);
   assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
   assign out_eof   = out_valid & head[OUT_W];
   assign out_sof   = out_valid & head[OUT_W+1];

`ifdef LDPC_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Counts end-of-frame words that actually entered the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n)
         frame_cnt_q <= '0;
      else if (do_push && word_last)
         frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_ldpc_frame_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ldpc_frame_io_ctrl
//
// Self-checking bench for ldpc_frame_io_ctrl with K_BITS=8, N_WORDS=4,
// FIFO_DEPTH=4, OUT_W=19, BIT_SEL=5. Every cycle goes through tick(), which
// keeps a small frame/FIFO model and pushes expected output words into a
// queue; a negedge monitor pops and compares them when a transfer happens.
// Scenario tasks check flags and core-side outputs inline.
// ---------------------------------------------------------------------------
module tb_ldpc_frame_io_ctrl;

   localparam int K_B   = 8;
   localparam int N_W   = 4;
   localparam int DEPTH = 4;
   localparam int S_IDLE  = 0;
   localparam int S_LOAD  = 1;
   localparam int S_DRAIN = 2;

   typedef struct packed {
      logic        sof;
      logic        eof;
      logic [18:0] data;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n, clk_enable, pkt_valid, enc_valid, out_ready;
   logic [5:0]  pkt_in;
   logic [18:0] enc_data;
   logic        next_frame, core_bit, core_bit_vld, core_start;
   logic        out_valid, out_sof, out_eof, ovf_err, proto_err;
   logic [18:0] out_data;
   logic [15:0] frame_cnt;

   int          checks = 0;
   int          errors = 0;
   bit          mon_on = 0;
   entry_t      exp_q[$];
   entry_t      mon_e;
   int          m_state = S_IDLE;
   int          m_bits = 0;
   int          m_words = 0;
   int          m_cnt = 0;
   logic [15:0] m_frames = '0;

   ldpc_frame_io_ctrl #(
      .PKT_W(6), .BIT_SEL(5), .K_BITS(K_B), .N_WORDS(N_W),
      .OUT_W(19), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
      .pkt_in(pkt_in), .pkt_valid(pkt_valid), .next_frame(next_frame),
      .core_bit(core_bit), .core_bit_vld(core_bit_vld), .core_start(core_start),
      .enc_valid(enc_valid), .enc_data(enc_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
      .out_eof(out_eof), .ovf_err(ovf_err), .proto_err(proto_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fc_exp();
`ifdef LDPC_FRAME_CNT_EN
      return m_frames;
`else
      return 16'h0;
`endif
   endfunction

   // Scoreboard monitor: out_valid against model occupancy, and every
   // transfer against the oldest expected entry.
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (out_valid !== (m_cnt != 0)) begin
            errors++;
            $display("[TB] FAIL out_valid: got %b expected %b at %0t", out_valid, (m_cnt != 0), $time);
         end
         if (rst_n && clk_enable && out_ready && (m_cnt != 0)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL scoreboard: transfer with got %h but expected queue empty", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               if ({out_sof, out_eof, out_data} !== mon_e) begin
                  errors++;
                  $display("[TB] FAIL out_word: got sof=%b eof=%b data=%h expected sof=%b eof=%b data=%h",
                           out_sof, out_eof, out_data, mon_e.sof, mon_e.eof, mon_e.data);
               end
            end
         end
      end
   end

   // One clock cycle: update the model from the inputs already driven, then
   // let the edge happen and return 1 time unit after it.
   task automatic tick();
      bit pop, push_ok, sof, eof, acc, take;
      int ns;
      @(negedge clk);
      #1;
      if (!rst_n) begin
         m_state = S_IDLE; m_bits = 0; m_words = 0; m_cnt = 0; m_frames = '0;
         exp_q.delete();
      end else if (clk_enable) begin
         pop     = out_ready && (m_cnt != 0);
         acc     = pkt_valid && (m_state != S_DRAIN);
         take    = enc_valid && (m_state != S_IDLE);
         ns      = m_state;
         push_ok = 0;
         if (take) begin
            sof     = (m_words == 0);
            eof     = (m_words == N_W - 1);
            push_ok = (m_cnt < DEPTH) || pop;
            if (push_ok) begin
               exp_q.push_back(entry_t'({sof, eof, enc_data}));
               if (eof) m_frames++;
            end
            m_words = eof ? 0 : m_words + 1;
            if (eof && (m_state == S_DRAIN)) ns = S_IDLE;
         end
         if (acc) begin
            if (m_state == S_IDLE) begin
               ns = S_LOAD; m_bits = 1;
            end else if (m_bits == K_B - 1) begin
               ns = S_DRAIN; m_bits = 0;
            end else begin
               m_bits++;
            end
         end
         m_cnt   = m_cnt + (push_ok ? 1 : 0) - (pop ? 1 : 0);
         m_state = ns;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pkt_valid = 0; pkt_in = 6'h00; enc_valid = 0; enc_data = '0;
   endtask

   task automatic apply_bit(input bit b);
      pkt_valid = 1; pkt_in = b ? 6'h20 : 6'h00;
      tick();
      pkt_valid = 0;
   endtask

   task automatic apply_word(input logic [18:0] d);
      enc_valid = 1; enc_data = d;
      tick();
      enc_valid = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      clk_enable = 1; rst_n = 0;
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0; clk_enable = 1; out_ready = 0;
      idle_inputs();
      tick(); tick();
      checks++;
      if ({next_frame, core_bit, core_bit_vld, core_start, out_valid, out_data,
           out_sof, out_eof, ovf_err, proto_err, frame_cnt} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got nf=%b cb=%b vld=%b st=%b ov=%b od=%h sof=%b eof=%b ovf=%b pe=%b fc=%0d expected all 0",
                  next_frame, core_bit, core_bit_vld, core_start, out_valid, out_data,
                  out_sof, out_eof, ovf_err, proto_err, frame_cnt);
      end
      mon_on = 1;
      rst_n = 1;
      tick();
      checks++;
      if (next_frame !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_next_frame: got %b expected 1", next_frame);
      end
   endtask

   task automatic test_frame();
      out_ready = 1;
      for (int i = 0; i < K_B; i++) begin
         apply_bit(i % 2 == 0);
         checks++;
         if ({core_bit_vld, core_bit, core_start, next_frame} !== {1'b1, (i % 2 == 0), (i == 0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL frame_bit%0d: got vld=%b bit=%b start=%b nf=%b expected vld=1 bit=%b start=%b nf=0",
                     i, core_bit_vld, core_bit, core_start, next_frame, (i % 2 == 0), (i == 0));
         end
      end
      apply_bit(1);
      checks++;
      if (core_bit_vld !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_bit_ignored: got vld=%b expected 0", core_bit_vld);
      end
      for (int w = 1; w <= N_W; w++) begin
         apply_word(19'(w));
         if (w == 1) begin
            checks++;
            if ({out_valid, out_sof, out_data} !== {1'b1, 1'b1, 19'h1}) begin
               errors++;
               $display("[TB] FAIL word_latency: got ov=%b sof=%b data=%h expected ov=1 sof=1 data=1", out_valid, out_sof, out_data);
            end
         end
         checks++;
         if (next_frame !== (w == N_W)) begin
            errors++;
            $display("[TB] FAIL frame_next_w%0d: got %b expected %b", w, next_frame, (w == N_W));
         end
      end
      repeat (3) tick();
      checks++;
      if (frame_cnt !== fc_exp()) begin
         errors++;
         $display("[TB] FAIL frame_cnt_one: got %0d expected %0d", frame_cnt, fc_exp());
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      out_ready = 0;
      apply_bit(1);
      for (int w = 1; w <= 6; w++) begin
         apply_word(19'(w));
         if (w == 4 || w == 5) begin
            checks++;
            if (ovf_err !== (w == 5)) begin
               errors++;
               $display("[TB] FAIL ovf_w%0d: got %b expected %b", w, ovf_err, (w == 5));
            end
         end
      end
      checks++;
      if ({out_valid, out_sof, out_eof, out_data} !== {1'b1, 1'b1, 1'b0, 19'h1}) begin
         errors++;
         $display("[TB] FAIL ovf_head_stable: got ov=%b sof=%b eof=%b data=%h expected 1 1 0 00001",
                  out_valid, out_sof, out_eof, out_data);
      end
      out_ready = 1;
      repeat (5) tick();
      for (int i = 0; i < K_B - 1; i++) apply_bit(i % 2 == 1);
      apply_word(19'h7);
      apply_word(19'h8);
      checks++;
      if (next_frame !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_frame_end: got nf=%b expected 1", next_frame);
      end
      repeat (3) tick();
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      out_ready = 0;
      apply_bit(0);
      for (int w = 0; w < DEPTH; w++) apply_word(19'h11 + 19'(w));
      out_ready = 1;
      apply_word(19'h15);
      checks++;
      if (ovf_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_push_pop_ovf: got %b expected 0", ovf_err);
      end
      out_ready = 0;
      apply_word(19'h16);
      checks++;
      if (ovf_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL full_still_full: got ovf=%b expected 1", ovf_err);
      end
      out_ready = 1;
      repeat (5) tick();
   endtask

   task automatic test_proto_and_reset();
      apply_reset();
      apply_word(19'h3F);
      checks++;
      if ({proto_err, out_valid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL proto: got pe=%b ov=%b expected pe=1 ov=0", proto_err, out_valid);
      end
      for (int i = 0; i < 5; i++) apply_bit(i % 2 == 0);
      rst_n = 0; pkt_valid = 1; pkt_in = 6'h20;
      tick();
      checks++;
      if ({next_frame, core_bit, core_bit_vld, core_start, out_valid, out_data,
           out_sof, out_eof, ovf_err, proto_err, frame_cnt} !== '0) begin
         errors++;
         $display("[TB] FAIL midload_reset: got nf=%b cb=%b vld=%b st=%b ov=%b pe=%b expected all 0",
                  next_frame, core_bit, core_bit_vld, core_start, out_valid, proto_err);
      end
      rst_n = 1; pkt_valid = 0;
      tick();
      apply_bit(1);
      checks++;
      if ({core_start, core_bit_vld} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL restart_after_reset: got start=%b vld=%b expected 1 1", core_start, core_bit_vld);
      end
   endtask

   task automatic test_clk_enable();
      apply_reset();
      out_ready = 0;
      apply_bit(1);
      enc_valid = 1; enc_data = 19'h21;
      apply_bit(0);
      enc_valid = 0;
      apply_bit(1);
      clk_enable = 0; pkt_valid = 1; pkt_in = 6'h00; enc_valid = 1; enc_data = 19'h22; out_ready = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({core_bit, core_bit_vld, core_start, next_frame, out_valid, out_data} !==
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 19'h21}) begin
            errors++;
            $display("[TB] FAIL freeze_c%0d: got cb=%b vld=%b st=%b nf=%b ov=%b od=%h expected 1 1 0 0 1 00021",
                     c, core_bit, core_bit_vld, core_start, next_frame, out_valid, out_data);
         end
      end
      clk_enable = 1;
      idle_inputs();
      out_ready = 0;
      for (int i = 3; i < K_B; i++) begin
         apply_bit(i % 2 == 0);
         checks++;
         if ({core_bit_vld, core_bit, core_start} !== {1'b1, (i % 2 == 0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL resume_bit%0d: got vld=%b bit=%b start=%b expected 1 %b 0",
                     i, core_bit_vld, core_bit, core_start, (i % 2 == 0));
         end
      end
      apply_bit(1);
      checks++;
      if (core_bit_vld !== 1'b0) begin
         errors++;
         $display("[TB] FAIL resume_count_exact: got vld=%b expected 0", core_bit_vld);
      end
      out_ready = 1;
      for (int w = 0; w < N_W - 1; w++) apply_word(19'h23 + 19'(w));
      checks++;
      if (next_frame !== 1'b1) begin
         errors++;
         $display("[TB] FAIL resume_frame_end: got nf=%b expected 1", next_frame);
      end
      repeat (6) tick();
      checks++;
      if (exp_q.size() != 0 || frame_cnt !== fc_exp()) begin
         errors++;
         $display("[TB] FAIL final_drain: got pending=%0d fc=%0d expected pending=0 fc=%0d",
                  exp_q.size(), frame_cnt, fc_exp());
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_overflow();
      test_full_push_pop();
      test_proto_and_reset();
      test_clk_enable();
      mon_on = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
